// File: rtl/sipo_word_collector.sv
// Serial-in/parallel-out collector: assembles LENGTH handshaked bits into a word
// and holds it under a valid/ready handshake for the downstream AND stage.
module sipo_word_collector #(
  parameter int unsigned LENGTH    = 4,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CW        = $clog2(LENGTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              flush,
  output logic [LENGTH-1:0] x_out,
  output logic              x_valid,
  input  logic              x_ready,
  output logic [CW-1:0]     bit_cnt
);

  typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  state_t              r_state;
  logic [LENGTH-1:0]   r_shadow;
  logic [LENGTH-1:0]   r_x_out;
  logic                r_x_valid;
  logic                r_bit_ready;
  logic [CW-1:0]       r_bit_cnt;

  state_t              w_state_nxt;
  logic [LENGTH-1:0]   w_shadow_nxt;
  logic [LENGTH-1:0]   w_x_out_nxt;
  logic                w_x_valid_nxt;
  logic                w_bit_ready_nxt;
  logic [CW-1:0]       w_bit_cnt_nxt;
  logic [CW-1:0]       w_idx;
  logic [LENGTH-1:0]   w_word;
  logic                w_accept;

  // bit_ready is only ever high in COLLECT, so it alone qualifies an accept
  assign w_accept = bit_valid & r_bit_ready;
  assign w_idx    = LSB_FIRST ? r_bit_cnt : (CNT_LAST - r_bit_cnt);

  // Shadow word with the incoming bit inserted at its slot
  always_comb begin
    w_word = r_shadow;
    for (int i = 0; i < int'(LENGTH); i++) begin
      if (w_idx == CW'(i)) begin
        w_word[i] = bit_in;
      end else begin
        w_word[i] = r_shadow[i];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_x_out_nxt     = r_x_out;
    w_x_valid_nxt   = r_x_valid;
    w_bit_ready_nxt = r_bit_ready;
    w_bit_cnt_nxt   = r_bit_cnt;
    case (r_state)
      S_COLLECT: begin
        w_bit_ready_nxt = 1'b1;
        if (flush) begin
          w_bit_cnt_nxt = '0;
          w_shadow_nxt  = '0;
        end else if (w_accept) begin
          if (r_bit_cnt == CNT_LAST) begin
            w_x_out_nxt     = w_word;
            w_x_valid_nxt   = 1'b1;
            w_bit_cnt_nxt   = '0;
            w_shadow_nxt    = '0;
            w_state_nxt     = S_HOLD;
            w_bit_ready_nxt = 1'b0;
          end else begin
            w_shadow_nxt  = w_word;
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end
      S_HOLD: begin
        w_bit_ready_nxt = 1'b0;
        if (r_x_valid && x_ready) begin
          w_x_valid_nxt   = 1'b0;
          w_state_nxt     = S_COLLECT;
          w_bit_ready_nxt = 1'b1;
        end else begin
          w_x_valid_nxt = r_x_valid;
        end
      end
      default: begin
        w_state_nxt     = S_COLLECT;
        w_bit_ready_nxt = 1'b0;
        w_x_valid_nxt   = 1'b0;
        w_bit_cnt_nxt   = '0;
        w_shadow_nxt    = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_COLLECT;
      r_shadow    <= '0;
      r_x_out     <= '0;
      r_x_valid   <= 1'b0;
      r_bit_ready <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_x_out     <= w_x_out_nxt;
      r_x_valid   <= w_x_valid_nxt;
      r_bit_ready <= w_bit_ready_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
    end
  end

  assign bit_ready = r_bit_ready;
  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Bench for sipo_word_collector: LSB-first and MSB-first instances share one
// stimulus stream and are checked against a queue-based word model.
module tb_sipo_word_collector;

  localparam int unsigned LENGTH = 4;
  localparam int unsigned CW     = $clog2(LENGTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_valid;
  logic              flush;
  logic              x_ready;
  logic              bit_ready_l, bit_ready_m;
  logic [LENGTH-1:0] x_out_l, x_out_m;
  logic              x_valid_l, x_valid_m;
  logic [CW-1:0]     bit_cnt_l, bit_cnt_m;

  int checks;
  int failures;

  bit                m_bits[$];
  bit                m_hold;
  bit                m_valid;
  bit                m_ready;
  logic [LENGTH-1:0] m_word_l;
  logic [LENGTH-1:0] m_word_m;

  sipo_word_collector #(.LENGTH(LENGTH), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .flush(flush), .x_out(x_out_l),
    .x_valid(x_valid_l), .x_ready(x_ready), .bit_cnt(bit_cnt_l)
  );

  sipo_word_collector #(.LENGTH(LENGTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .flush(flush), .x_out(x_out_m),
    .x_valid(x_valid_m), .x_ready(x_ready), .bit_cnt(bit_cnt_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word value from the accepted bits: k-th bit weighs 2^k (LSB first) or 2^(L-1-k)
  function automatic logic [LENGTH-1:0] pack(input bit lsb);
    int unsigned acc;
    acc = 0;
    for (int k = 0; k < m_bits.size(); k++) begin
      if (m_bits[k]) acc = acc + (lsb ? (1 << k) : (1 << (LENGTH - 1 - k)));
    end
    return LENGTH'(acc);
  endfunction

  task automatic check_all();
    chk("bit_ready_l", 32'(bit_ready_l), 32'(m_ready));
    chk("bit_ready_m", 32'(bit_ready_m), 32'(m_ready));
    chk("x_valid_l",   32'(x_valid_l),   32'(m_valid));
    chk("x_valid_m",   32'(x_valid_m),   32'(m_valid));
    chk("x_out_l",     32'(x_out_l),     32'(m_word_l));
    chk("x_out_m",     32'(x_out_m),     32'(m_word_m));
    chk("and_y",       32'(&x_out_l),    32'(&m_word_l));
    chk("bit_cnt_l",   32'(bit_cnt_l),   32'(m_bits.size()));
    chk("bit_cnt_m",   32'(bit_cnt_m),   32'(m_bits.size()));
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_hold   = 1'b0;
    m_valid  = 1'b0;
    m_ready  = 1'b0;
    m_word_l = '0;
    m_word_m = '0;
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs
  task automatic step(input bit b, input bit v, input bit f, input bit xr);
    bit_in    = b;
    bit_valid = v;
    flush     = f;
    x_ready   = xr;
    @(posedge clk);
    if (m_hold) begin
      if (xr) begin
        m_hold  = 1'b0;
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end else begin
      if (f) begin
        m_bits.delete();
      end else if (v && m_ready) begin
        m_bits.push_back(b);
        if (m_bits.size() == LENGTH) begin
          m_word_l = pack(1'b1);
          m_word_m = pack(1'b0);
          m_valid  = 1'b1;
          m_hold   = 1'b1;
          m_bits.delete();
        end
      end
      m_ready = !m_hold;
    end
    #1;
    check_all();
  endtask

  task automatic send(input bit b);
    step(b, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    flush     = 1'b0;
    x_ready   = 1'b0;
    model_reset();
    #1;
    check_all();
    #11 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // all-ones word, consumer always ready
    send(1'b1); send(1'b1); send(1'b1); send(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 1,0,1,1 with two idle cycles between bits
    send(1'b1); step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0); step(1'b1, 1'b0, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1); step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 1,0,0,0 gives 0001 LSB-first and 1000 MSB-first; then backpressure
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'(i), 1'(i + 1), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // flush drops the partial word and the bit offered with it
    send(1'b1); send(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-word and mid-HOLD
    send(1'b1); send(1'b0);
    async_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0); send(1'b1); send(1'b1); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_word_collector.md
Name: sipo_word_collector

Overview:
Serial-in/parallel-out front end for the N-input AND reduction stage. It accepts a bit stream under a valid/ready handshake and assembles LENGTH bits into one word. It presents the completed word on x_out, which drives the AND stage's x input directly. The word is held stable under a valid/ready handshake until the consumer accepts it.

Parameters:
LENGTH, 4, word width in bits; must be >= 1; must equal the downstream AND stage's LENGTH.
LSB_FIRST, 1, 1: first accepted bit lands in x_out[0]; 0: first accepted bit lands in x_out[LENGTH-1].

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
bit_in  input  1  serial data bit.
bit_valid  input  1  bit_in is valid this cycle.
bit_ready  output  1  collector can accept a bit this cycle.
flush  input  1  synchronous discard of a partially collected word.
x_out  output  LENGTH  completed word, fed to the AND stage's x.
x_valid  output  1  x_out holds a complete, unconsumed word.
x_ready  input  1  consumer accepts x_out this cycle.
bit_cnt  output  CW  bits collected so far in the current word; CW = $clog2(LENGTH)+1.

Behaviour:
- Reset, asynchronous on rst_n low, all values effective immediately:
  - state=COLLECT, bit_cnt=0, shadow register=0, x_out=0, x_valid=0, bit_ready=0.
  - bit_ready is registered; it goes to 1 on the first rising edge after rst_n rises.
- States: COLLECT, HOLD.
- COLLECT:
  - bit_ready=1.
  - Accept occurs when bit_valid & bit_ready at a rising edge.
  - On accept, bit_in is written into the shadow register:
    - LSB_FIRST=1: at index bit_cnt.
    - LSB_FIRST=0: at index LENGTH-1-bit_cnt.
  - On accept, bit_cnt increments.
  - Gaps in bit_valid are allowed; partial state is held indefinitely.
- Word completion: an accept with bit_cnt==LENGTH-1. At that same edge:
  - x_out <= full word, including the bit just accepted.
  - x_valid <= 1.
  - bit_cnt <= 0.
  - Shadow register cleared to 0.
  - state <= HOLD.
  - bit_ready <= 0.
- Latency: x_valid rises on the edge that accepts the last bit. Observed the cycle after the last bit is presented.
- HOLD:
  - bit_ready=0; bit_in/bit_valid are ignored.
  - x_out and x_valid are held stable regardless of any input except reset.
  - When x_valid & x_ready at an edge: x_valid <= 0, state <= COLLECT, bit_ready <= 1.
  - x_out keeps its last value after consumption; consumers qualify it with x_valid.
- Throughput: one word per LENGTH+1 cycles when the stream and consumer never stall.
- flush:
  - In COLLECT: bit_cnt <= 0 and shadow <= 0. flush has priority over a simultaneous accept; that bit is dropped.
  - In HOLD: no effect. The held word is not discarded.
- x_ready while x_valid=0: ignored.
- LENGTH=1: every accept completes a word; bit_cnt stays 0.
- bit_cnt never exceeds LENGTH-1.
- Reset mid-word or mid-HOLD: all partial and held data is lost; the reset values above apply.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
1. LENGTH=4, LSB_FIRST=1: send bits 1,1,1,1 on consecutive cycles, x_ready=1 → x_out=4'b1111 and x_valid=1 for one cycle; downstream AND y=1; bit_ready low for that cycle, then high.
2. LENGTH=4, LSB_FIRST=1: send 1,0,1,1 with bit_valid gaps of 2 cycles between bits → x_out=4'b1101; y=0; bit_cnt steps 0,1,2,3,0.
3. LENGTH=4, LSB_FIRST=0: send 1,0,0,0 → x_out=4'b1000.
4. Backpressure: complete a word with x_ready=0 for 5 cycles while toggling bit_in/bit_valid → x_valid=1 and x_out stable throughout; bit_ready=0; no bits counted. Raise x_ready → x_valid=0 next edge, bit_ready=1.
5. flush: send 1,1, then flush=1 with bit_valid=1, then 0,1,1,1 → bit_cnt=0 after the flush; the flush-cycle bit is dropped; x_out=4'b1110. flush asserted in HOLD → held word unchanged.
6. Reset: assert rst_n=0 asynchronously mid-word (bit_cnt=2) and again in HOLD → immediately x_valid=0, x_out=0, bit_cnt=0, bit_ready=0. After release, a fresh 4-bit word is collected correctly.
